// File: rtl/fft_pkg.sv
// Shared FFT constants, sample type and bit-reversal helper.
package fft_pkg;
  localparam int W     = 16;
  localparam int N     = 16;
  localparam int LOG2N = 4;

  typedef logic signed [W-1:0] sample_t;

  // Reverse the LOG2N-bit index (DIT input ordering).
  function automatic logic [LOG2N-1:0] bitrev4(input logic [LOG2N-1:0] idx);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) r[b] = idx[LOG2N-1-b];
    return r;
  endfunction
endpackage

// File: rtl/fft16_frame_loader_if.sv
// Sample stream in, parallel frame out, plus framing-error pulse.
interface fft16_frame_loader_if;
  import fft_pkg::*;
  logic             s_valid;
  logic             s_ready;
  logic [W-1:0]     s_re;
  logic [W-1:0]     s_im;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [N*W-1:0]   m_re;
  logic [N*W-1:0]   m_im;
  logic             err_frame;

  // Loader side.
  modport slave (input s_valid, s_re, s_im, s_last, m_ready,
                 output s_ready, m_valid, m_re, m_im, err_frame);
  // Producer / FFT side.
  modport master (output s_valid, s_re, s_im, s_last, m_ready,
                  input s_ready, m_valid, m_re, m_im, err_frame);
endinterface

// File: rtl/fft_frame_bank.sv
// N-slot complex register bank: one write port, all slots read flattened.
module fft_frame_bank import fft_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [LOG2N-1:0] addr_i,
  input  sample_t          re_i,
  input  sample_t          im_i,
  output logic [N*W-1:0]   re_o,
  output logic [N*W-1:0]   im_o
);
  for (genvar k = 0; k < N; k++) begin : g_slot
    sample_t re_q, im_q;
    // Slot k captures the sample when addressed.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        re_q <= '0;
        im_q <= '0;
      end else if (we_i && addr_i == LOG2N'(k)) begin
        re_q <= re_i;
        im_q <= im_i;
      end
    end
    assign re_o[k*W +: W] = re_q;
    assign im_o[k*W +: W] = im_q;
  end
endmodule

// File: rtl/fft16_frame_loader.sv
// Ping-pong frame loader: samples stored bit-reversed, full frames shown in parallel.
module fft16_frame_loader import fft_pkg::*; (
  input logic                 clk,
  input logic                 rst_n,
  fft16_frame_loader_if.slave bus
);
  logic [LOG2N-1:0] cnt_q;
  logic             wbank_q, rbank_q, err_q;
  logic [1:0]       full_q;
  logic             acc, cons;
  logic [N*W-1:0]   bank_re [2];
  logic [N*W-1:0]   bank_im [2];

  assign bus.s_ready   = !full_q[wbank_q];
  assign bus.m_valid   = full_q[rbank_q];
  assign bus.err_frame = err_q;
  assign acc  = bus.s_valid && bus.s_ready;
  assign cons = bus.m_valid && bus.m_ready;

  // Writes only ever land in the non-full write bank, so the read bank stays stable.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_bank u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we_i  (acc && (wbank_q == 1'(b))),
      .addr_i(bitrev4(cnt_q)),
      .re_i  (bus.s_re),
      .im_i  (bus.s_im),
      .re_o  (bank_re[b]),
      .im_o  (bank_im[b])
    );
  end

  assign bus.m_re = bank_re[rbank_q];
  assign bus.m_im = bank_im[rbank_q];

  // Frame counter, bank pointers, full flags and framing-error pulse.
  // Completion and consume always hit different banks, so both may apply at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      full_q  <= 2'b00;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (cons) begin
        full_q[rbank_q] <= 1'b0;
        rbank_q         <= ~rbank_q;
      end
      if (acc) begin
        if (cnt_q == LOG2N'(N-1)) begin
          full_q[wbank_q] <= 1'b1;
          wbank_q         <= ~wbank_q;
          cnt_q           <= '0;
          err_q           <= !bus.s_last;
        end else if (bus.s_last) begin
          cnt_q <= '0;          // early last: drop the partial frame
          err_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fft16_frame_loader.sv
// Scoreboard bench: driver streams samples, monitor checks against a frame-level model.
module tb_fft16_frame_loader;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft16_frame_loader_if bus();
  fft16_frame_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { logic [N*W-1:0] re; logic [N*W-1:0] im; } frame_t;

  int total = 0;
  int bad = 0;
  frame_t       exp_q[$];
  logic [W-1:0] cur_re[$];
  logic [W-1:0] cur_im[$];
  bit           err_pend = 1'b0;

  task automatic chk(input string nm, input logic [N*W-1:0] act, input logic [N*W-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, expv);
    end
  endtask

  function automatic int rev(input int k);
    return ((k % 2) * 8) + (((k / 2) % 2) * 4) + (((k / 4) % 2) * 2) + ((k / 8) % 2);
  endfunction

  // Monitor / reference model: frames are lists of accepted samples, at most two pending.
  initial begin
    frame_t f;
    bit rdy_m, val_m;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        cur_re.delete();
        cur_im.delete();
        err_pend = 1'b0;
      end else begin
        val_m = exp_q.size() > 0;
        rdy_m = exp_q.size() < 2;
        chk("m_valid", N*W'(bus.m_valid), N*W'(val_m));
        chk("s_ready", N*W'(bus.s_ready), N*W'(rdy_m));
        chk("err_frame", N*W'(bus.err_frame), N*W'(err_pend));
        err_pend = 1'b0;
        if (val_m && bus.m_ready) begin
          f = exp_q.pop_front();
          chk("frame_re", bus.m_re, f.re);
          chk("frame_im", bus.m_im, f.im);
        end
        if (bus.s_valid && rdy_m) begin
          cur_re.push_back(bus.s_re);
          cur_im.push_back(bus.s_im);
          if (cur_re.size() == N) begin
            for (int k = 0; k < N; k++) begin
              f.re[k*W +: W] = cur_re[rev(k)];
              f.im[k*W +: W] = cur_im[rev(k)];
            end
            exp_q.push_back(f);
            err_pend = !bus.s_last;
            cur_re.delete();
            cur_im.delete();
          end else if (bus.s_last) begin
            err_pend = 1'b1;
            cur_re.delete();
            cur_im.delete();
          end
        end
      end
    end
  end

  // Present one sample and hold it until accepted (bounded).
  task automatic send(input logic [W-1:0] re, input logic [W-1:0] im, input bit last);
    int g = 0;
    bit ok;
    bus.s_valid = 1'b1;
    bus.s_re    = re;
    bus.s_im    = im;
    bus.s_last  = last;
    do begin
      ok = bus.s_ready;
      @(posedge clk); #1;
      g++;
    end while (!ok && g < 200);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout act=not_accepted exp=accepted");
    end
  endtask

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int  k;
    bit  a;
    bus.s_valid = 1'b0; bus.s_re = '0; bus.s_im = '0; bus.s_last = 1'b0; bus.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", N*W'(bus.m_valid), '0);
    chk("rst_s_ready", N*W'(bus.s_ready), N*W'(1));
    chk("rst_err", N*W'(bus.err_frame), '0);
    chk("rst_m_re", bus.m_re, '0);
    chk("rst_m_im", bus.m_im, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single ramp frame, held until inspected.
    for (int n = 0; n < N; n++) send(W'(n), W'(-n), n == N-1);
    bus.s_valid = 1'b0;
    chk("latency_m_valid", N*W'(bus.m_valid), N*W'(1));
    chk("slot1_re", N*W'(bus.m_re[1*W +: W]), N*W'(8));
    chk("slot3_re", N*W'(bus.m_re[3*W +: W]), N*W'(12));
    chk("slot15_re", N*W'(bus.m_re[15*W +: W]), N*W'(15));
    chk("slot3_im", N*W'(bus.m_im[3*W +: W]), N*W'(16'hfff4));
    bus.m_ready = 1'b1;
    idle(3);

    // Three back-to-back frames with an always-ready consumer.
    for (int f = 0; f < 3; f++)
      for (int n = 0; n < N; n++) send(W'($urandom), W'($urandom), n == N-1);
    idle(3);

    // Backpressure: fill both banks, 33rd sample waits for one consume.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 2*N; i++) send(W'($urandom), W'($urandom), (i % N) == N-1);
    bus.s_valid = 1'b1; bus.s_re = W'($urandom); bus.s_im = W'($urandom); bus.s_last = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("full_s_ready", N*W'(bus.s_ready), '0);
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    chk("after_consume_s_ready", N*W'(bus.s_ready), N*W'(1));
    chk("after_consume_m_valid", N*W'(bus.m_valid), N*W'(1));
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    for (int n = 1; n < N; n++) send(W'($urandom), W'($urandom), n == N-1);
    idle(4);

    // Early s_last on the 9th sample, then a good frame.
    for (int n = 0; n < 9; n++) send(W'($urandom), W'($urandom), n == 8);
    for (int n = 0; n < N; n++) send(W'($urandom), W'($urandom), n == N-1);
    idle(3);

    // Reset mid-frame after 7 samples, then impulse frame.
    for (int n = 0; n < 7; n++) send(W'($urandom), W'($urandom), 1'b0);
    bus.s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", N*W'(bus.m_valid), '0);
    chk("midrst_s_ready", N*W'(bus.s_ready), N*W'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < N; n++) send((n == 0) ? W'(16384) : W'(0), W'(0), n == N-1);
    idle(3);

    // Random traffic with random backpressure and occasional framing errors.
    k = 0;
    for (int i = 0; i < 1500; i++) begin
      a = bus.s_valid && bus.s_ready;
      @(posedge clk); #1;
      if (a) k = (k == N-1 || bus.s_last) ? 0 : k + 1;
      if (a || !bus.s_valid) begin
        bus.s_valid = ($urandom_range(0, 3) != 0);
        bus.s_re    = W'($urandom);
        bus.s_im    = W'($urandom);
        bus.s_last  = (k == N-1) ^ ($urandom_range(0, 19) == 0);
      end
      bus.m_ready = ($urandom_range(0, 2) != 0);
    end
    bus.m_ready = 1'b1;
    idle(5);
    chk("drain_m_valid", N*W'(bus.m_valid), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
